// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divide/remainder unit.
package div_pkg;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      CALC   = 2'b01,
      FINISH = 2'b10
   } div_state_t;

   localparam int DIV_ITER = 32;
   localparam int DIV_LAT  = 33;

   function automatic logic [31:0] twos_neg(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
      return neg ? twos_neg(v) : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift {rem, quo} left, trial subtract, set quotient LSB.
module div_step
   import div_pkg::*;
(
   input  logic [31:0] rem,
   input  logic [31:0] quo,
   input  logic [31:0] divisor,
   output logic [31:0] next_rem,
   output logic [31:0] next_quo
);

   logic [32:0] shifted_s;
   logic        fits_s;

   // 33-bit compare keeps a 0x80000000 magnitude divisor representable
   always_comb begin
      shifted_s = {rem, quo[31]};
      fits_s    = (shifted_s >= {1'b0, divisor});
      if (fits_s) begin
         next_rem = shifted_s[31:0] - divisor;
         next_quo = {quo[30:0], 1'b1};
      end else begin
         next_rem = shifted_s[31:0];
         next_quo = {quo[30:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU/REM/REMU unit with Start/Busy/Done handshake.
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed overflow finish one cycle after acceptance.
module div_unit
   import div_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [1:0]  Op,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   input  logic        Flush,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] Result
);

   localparam logic [4:0] LAST_STEP = 5'(DIV_ITER - 1);

   div_state_t  state_r;
   div_op_t     op_r;
   logic [31:0] rem_r;
   logic [31:0] quo_r;
   logic [31:0] divisor_r;
   logic        neg_a_r;
   logic        neg_b_r;
   logic        dbz_r;
   logic [4:0]  count_r;

   logic        signed_s;
   logic        neg_a_s;
   logic        neg_b_s;
   logic [31:0] a_mag_s;
   logic [31:0] b_mag_s;
   logic [31:0] next_rem_s;
   logic [31:0] next_quo_s;
   logic [31:0] quo_fix_s;
   logic [31:0] rem_fix_s;
   logic [31:0] result_s;

   // operand decode for the accepting cycle
   always_comb begin
      signed_s = ~Op[0];
      neg_a_s  = signed_s & SrcA[31];
      neg_b_s  = signed_s & SrcB[31];
      a_mag_s  = magnitude(SrcA, neg_a_s);
      b_mag_s  = magnitude(SrcB, neg_b_s);
   end

`ifdef DIV_FASTPATH_EN
   logic fast_s;

   // cases whose result is known at acceptance
   always_comb begin
      fast_s = (SrcB == 32'd0) |
               (signed_s & (SrcA == 32'h8000_0000) & (SrcB == 32'hFFFF_FFFF));
   end
`endif

   div_step u_step (
      .rem      (rem_r),
      .quo      (quo_r),
      .divisor  (divisor_r),
      .next_rem (next_rem_s),
      .next_quo (next_quo_s)
   );

   // sign correction, divide-by-zero override and result select
   always_comb begin
      if (dbz_r) begin
         quo_fix_s = 32'hFFFF_FFFF;
      end else if (neg_a_r ^ neg_b_r) begin
         quo_fix_s = twos_neg(quo_r);
      end else begin
         quo_fix_s = quo_r;
      end
      if (neg_a_r) begin
         rem_fix_s = twos_neg(rem_r);
      end else begin
         rem_fix_s = rem_r;
      end
      if (op_r[1]) begin
         result_s = rem_fix_s;
      end else begin
         result_s = quo_fix_s;
      end
   end

   // control FSM with registered Busy/Done/Result and the iteration datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         op_r      <= DIV;
         rem_r     <= 32'd0;
         quo_r     <= 32'd0;
         divisor_r <= 32'd0;
         neg_a_r   <= 1'b0;
         neg_b_r   <= 1'b0;
         dbz_r     <= 1'b0;
         count_r   <= 5'd0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         Result    <= 32'd0;
      end else if (Flush) begin
         state_r <= IDLE;
         Busy    <= 1'b0;
         Done    <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (Start) begin
                  op_r      <= div_op_t'(Op);
                  neg_a_r   <= neg_a_s;
                  neg_b_r   <= neg_b_s;
                  dbz_r     <= (SrcB == 32'd0);
                  divisor_r <= b_mag_s;
                  rem_r     <= 32'd0;
                  quo_r     <= a_mag_s;
                  count_r   <= 5'd0;
                  Busy      <= 1'b1;
                  state_r   <= CALC;
`ifdef DIV_FASTPATH_EN
                  // preload what the full iteration would have left behind
                  if (fast_s) begin
                     state_r <= FINISH;
                     if (SrcB == 32'd0) begin
                        rem_r <= a_mag_s;
                        quo_r <= 32'hFFFF_FFFF;
                     end else begin
                        rem_r <= 32'd0;
                        quo_r <= 32'h8000_0000;
                     end
                  end
`endif
               end
            end
            CALC: begin
               rem_r   <= next_rem_s;
               quo_r   <= next_quo_s;
               count_r <= count_r + 5'd1;
               if (count_r == LAST_STEP) begin
                  state_r <= FINISH;
               end
            end
            FINISH: begin
               Result  <= result_s;
               Done    <= 1'b1;
               Busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               Busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed plan vectors, random ops against a reference model, handshake scenarios.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        Flush;
   logic        Busy;
   logic        Done;
   logic [31:0] Result;

   int n_cmp = 0;
   int n_bad = 0;

   logic [1:0]  t_op  [8] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10};
   logic [31:0] t_a   [8] = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'h8000_0000, 32'h8000_0000};
   logic [31:0] t_b   [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h10, 32'h10,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   logic [31:0] t_exp [8] = '{32'hFFFF_FFF2, 32'h2, 32'h0FFF_FFFF, 32'hF,
                              32'hFFFF_FFFF, 32'hFFFF_FFEC, 32'h8000_0000, 32'h0};

   always #5 clk = ~clk;

   div_unit dut (
      .clk    (clk),
      .reset  (reset),
      .Start  (Start),
      .Op     (Op),
      .SrcA   (SrcA),
      .SrcB   (SrcB),
      .Flush  (Flush),
      .Busy   (Busy),
      .Done   (Done),
      .Result (Result)
   );

   // RISC-V M-extension semantics in plain arithmetic
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic               ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         2'b00:   return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
         2'b01:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         2'b10:   return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FASTPATH_EN
      if (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
      return 33;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(1, 20));
         4:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // drive one Start and measure cycles from the accepting edge to Done (-1 on timeout)
   task automatic launch_and_wait(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output int lat, output logic [31:0] res,
                                  output logic busy_acc, output logic busy_done);
      @(negedge clk);
      Start = 1'b1; Op = op; SrcA = a; SrcB = b;
      @(posedge clk);
      #1 busy_acc = Busy;
      @(negedge clk);
      Start = 1'b0;
      lat = -1; res = 32'hDEAD_BEEF; busy_done = 1'bx;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (Done) begin
            lat = c; res = Result; busy_done = Busy;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; Start = 1'b0; Flush = 1'b0; Op = 2'b00; SrcA = 32'd0; SrcB = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (Busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got %b exp 0", Busy); end
      n_cmp++; if (Done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got %b exp 0", Done); end
      n_cmp++; if (Result !== 32'd0)  begin n_bad++; $display("FAIL reset_result got %h exp 0", Result); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_directed();
      int lat; logic [31:0] res; logic ba, bd;
      for (int i = 0; i < 8; i++) begin
         launch_and_wait(t_op[i], t_a[i], t_b[i], lat, res, ba, bd);
         n_cmp++; if (res !== t_exp[i]) begin n_bad++; $display("FAIL directed_result[%0d] got %h exp %h", i, res, t_exp[i]); end
         n_cmp++; if (lat != exp_lat(t_op[i], t_a[i], t_b[i])) begin n_bad++; $display("FAIL directed_latency[%0d] got %0d exp %0d", i, lat, exp_lat(t_op[i], t_a[i], t_b[i])); end
         n_cmp++; if (ba !== 1'b1) begin n_bad++; $display("FAIL directed_busy_accept[%0d] got %b exp 1", i, ba); end
         n_cmp++; if (bd !== 1'b0) begin n_bad++; $display("FAIL directed_busy_done[%0d] got %b exp 0", i, bd); end
      end
   endtask

   task automatic test_random();
      int lat; logic [31:0] res; logic ba, bd; logic [1:0] op; logic [31:0] a, b;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3)); a = pick_operand(); b = pick_operand();
         launch_and_wait(op, a, b, lat, res, ba, bd);
         n_cmp++; if (res !== model(op, a, b)) begin n_bad++; $display("FAIL random_result op=%0d a=%h b=%h got %h exp %h", op, a, b, res, model(op, a, b)); end
         n_cmp++; if (lat != exp_lat(op, a, b)) begin n_bad++; $display("FAIL random_latency op=%0d a=%h b=%h got %0d exp %0d", op, a, b, lat, exp_lat(op, a, b)); end
      end
   endtask

   task automatic test_ignored_start();
      int lat; int dones; logic [31:0] res;
      @(negedge clk);
      Start = 1'b1; Op = 2'b01; SrcA = 32'd1000; SrcB = 32'd7;
      @(posedge clk);
      lat = -1; dones = 0; res = 32'hDEAD_BEEF;
      for (int c = 1; c <= 70; c++) begin
         @(negedge clk);
         Start = (c == 10);
         if (c == 10) begin Op = 2'b00; SrcA = 32'd5; SrcB = 32'd1; end
         @(posedge clk);
         #1;
         if (Done) begin
            dones++;
            if (lat < 0) begin lat = c; res = Result; end
         end
      end
      n_cmp++; if (lat != 33)          begin n_bad++; $display("FAIL ignored_start_latency got %0d exp 33", lat); end
      n_cmp++; if (res !== 32'd142)    begin n_bad++; $display("FAIL ignored_start_result got %h exp %h", res, 32'd142); end
      n_cmp++; if (dones != 1)         begin n_bad++; $display("FAIL ignored_start_done_count got %0d exp 1", dones); end
      n_cmp++; if (Busy !== 1'b0)      begin n_bad++; $display("FAIL ignored_start_idle_busy got %b exp 0", Busy); end
   endtask

   task automatic test_flush();
      int lat; int seen; logic [31:0] res; logic ba, bd;
      @(negedge clk);
      Start = 1'b1; Op = 2'b00; SrcA = 32'd77; SrcB = 32'd3;
      @(posedge clk);
      seen = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         Start = (c == 10);
         Flush = (c == 20);
         @(posedge clk);
         #1;
         if (Done) seen++;
      end
      n_cmp++; if (seen != 0)           begin n_bad++; $display("FAIL flush_no_done got %0d pulses exp 0", seen); end
      n_cmp++; if (Busy !== 1'b0)       begin n_bad++; $display("FAIL flush_busy got %b exp 0", Busy); end
      n_cmp++; if (Result !== 32'd142)  begin n_bad++; $display("FAIL flush_result_held got %h exp %h", Result, 32'd142); end
      Flush = 1'b0;
      launch_and_wait(2'b11, 32'd1000, 32'd7, lat, res, ba, bd);
      n_cmp++; if (lat != 33)           begin n_bad++; $display("FAIL flush_restart_latency got %0d exp 33", lat); end
      n_cmp++; if (res !== 32'd6)       begin n_bad++; $display("FAIL flush_restart_result got %h exp 6", res); end
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] res; logic ba, bd; logic [1:0] op; logic [31:0] a, b;
      for (int i = 0; i < 4; i++) begin
         op = 2'($urandom_range(0, 3)); a = $urandom; b = 32'($urandom_range(1, 100000));
         launch_and_wait(op, a, b, lat, res, ba, bd);
         n_cmp++; if (res !== model(op, a, b)) begin n_bad++; $display("FAIL b2b_result[%0d] got %h exp %h", i, res, model(op, a, b)); end
         n_cmp++; if (lat != 33)   begin n_bad++; $display("FAIL b2b_latency[%0d] got %0d exp 33", i, lat); end
         n_cmp++; if (ba !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_accept[%0d] got %b exp 1", i, ba); end
      end
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] res; logic ba, bd;
      @(negedge clk);
      Start = 1'b1; Op = 2'b00; SrcA = 32'd123456; SrcB = 32'd3;
      @(posedge clk);
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         Start = 1'b0;
         reset = (c == 15);
         @(posedge clk);
      end
      #1;
      n_cmp++; if (Busy !== 1'b0)     begin n_bad++; $display("FAIL midreset_busy got %b exp 0", Busy); end
      n_cmp++; if (Done !== 1'b0)     begin n_bad++; $display("FAIL midreset_done got %b exp 0", Done); end
      n_cmp++; if (Result !== 32'd0)  begin n_bad++; $display("FAIL midreset_result got %h exp 0", Result); end
      reset = 1'b0;
      launch_and_wait(2'b10, 32'hFFFF_FF9C, 32'd7, lat, res, ba, bd);
      n_cmp++; if (res !== model(2'b10, 32'hFFFF_FF9C, 32'd7)) begin n_bad++; $display("FAIL midreset_recover got %h exp %h", res, model(2'b10, 32'hFFFF_FF9C, 32'd7)); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignored_start();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divide/remainder unit for the RISC-V integer pipeline, implementing DIV, DIVU, REM and REMU. It sits in the execute stage beside the single-cycle ALU. It accepts one operation through a Start/Busy/Done handshake and produces the result after a fixed multi-cycle latency. The hazard unit stalls the pipeline on Busy and the core can flush the unit on a redirect.

## Interface
- XLEN, 32: operand and result width; only 32 is supported.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  request; accepted only when Busy=0.
- Op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- SrcA  input  32  dividend (rs1).
- SrcB  input  32  divisor (rs2).
- Flush  input  1  abort any in-flight operation.
- Busy  output  1  operation in flight; reset 0.
- Done  output  1  one-cycle completion pulse; reset 0.
- Result  output  32  quotient or remainder; reset 0; holds until the next Done.

## Operation
- States: IDLE, CALC, FINISH.
- **IDLE**
  - If Start=1 and Flush=0: latch Op, the operand magnitudes, the sign flags, and DivByZero (SrcB==0). Clear the remainder register, set count=0, go to CALC.
- **CALC**
  - Each cycle runs one restoring step: shift {rem, quo} left by 1, trial subtract the divisor magnitude, keep the result if non-negative, and set the quotient LSB.
  - After the 32nd step (count==31), go to FINISH.
- **FINISH**
  - Apply sign correction:
    - Signed quotient is negated when sign(A) != sign(B).
    - Signed remainder takes the sign of A.
  - Apply overrides:
    - DivByZero forces the quotient to 0xFFFFFFFF. The remainder naturally equals SrcA.
    - Overflow (0x80000000 / 0xFFFFFFFF, DIV) gives quotient 0x80000000 and remainder 0 through the normal path; no override is needed.
  - Register Result, pulse Done, go to IDLE.
- Unsigned ops (DIVU/REMU) skip magnitude conversion and sign correction.
- Start while Busy=1 is ignored and never queued.
- Flush=1 in any state returns to IDLE next cycle with Done=0 and Result unchanged. Flush beats a simultaneous Start.
- reset mid-operation behaves like Flush and also clears Result to 0.

## Timing
- Start is accepted at edge k. Busy=1 from after edge k through the cycle containing edge k+33.
- CALC steps occur at edges k+1 through k+32. FINISH is evaluated in the cycle after edge k+32.
- Done=1 and Result valid in the cycle after edge k+33, so latency is 33 cycles.
- Busy=0 in the Done cycle. A Start in that cycle is accepted back-to-back, with throughput of one op per 34 cycles.
- Busy is a registered output decoded from state, with no combinational path from Start.
- The width rules:
  - Magnitude conversion uses 32-bit two's complement.
  - The trial subtract is 33 bits wide, so 0x80000000 is representable as a magnitude.

## Configuration
- Macro: DIV_FASTPATH_EN.
- **Defined:** at acceptance, DivByZero or signed overflow goes straight from IDLE to FINISH. Done follows one cycle after the accepting edge, with the same Result values.
- **Undefined:** every operation takes the full 33-cycle latency, giving fixed timing.

## Structure
- Shared package div_pkg:
  - div_op_t enum (DIV, DIVU, REM, REMU).
  - div_state_t enum (IDLE, CALC, FINISH).
  - DIV_ITER = 32.
  - DIV_LAT = 33.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem and quo.
  - Instantiated once inside div_unit.

## Test plan
- DIV 100 / -7 → Done after 33 cycles, Result 0xFFFFFFF2 (-14); REM of the same operands → 0x00000002.
- DIVU 0xFFFFFFFF / 0x10 → 0x0FFFFFFF; REMU → 0x0000000F.
- DIV of -20 by 0 → 0xFFFFFFFF; REM → 0xFFFFFFEC. Latency is 33 without DIV_FASTPATH_EN and 1 with it.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Start at cycle 0, second Start at cycle 10 (ignored), Flush at cycle 20 → no Done and Busy=0 at cycle 21. New Start at cycle 21 gives Done at cycle 54.
- Back-to-back: Start asserted in the Done cycle is accepted. reset at cycle 15 → Busy, Done and Result are all 0 next cycle.
